// File: rtl/rv32i_mc_control_unit_pkg.sv
// Shared encodings for the RV32I multicycle control unit: opcodes, ALU ops,
// write-back source selects and sequencer states.
package rv32i_mc_control_unit_pkg;

    localparam logic [6:0] OP_TYPE_R     = 7'b0110011;
    localparam logic [6:0] OP_TYPE_L     = 7'b0000011;
    localparam logic [6:0] OP_TYPE_I     = 7'b0010011;
    localparam logic [6:0] OP_TYPE_S     = 7'b0100011;
    localparam logic [6:0] OP_TYPE_B     = 7'b1100011;
    localparam logic [6:0] OP_TYPE_LUI   = 7'b0110111;
    localparam logic [6:0] OP_TYPE_AUIPC = 7'b0010111;
    localparam logic [6:0] OP_TYPE_JAL   = 7'b1101111;
    localparam logic [6:0] OP_TYPE_JALR  = 7'b1100111;

    localparam logic [3:0] ALU_ADD     = 4'b0000;
    localparam logic [2:0] FUNCT3_SLL  = 3'b001;
    localparam logic [2:0] FUNCT3_SR   = 3'b101;

    typedef enum logic [2:0] {
        RFWD_ALU    = 3'd0,
        RFWD_MEM    = 3'd1,
        RFWD_IMM    = 3'd2,
        RFWD_PC_IMM = 3'd3,
        RFWD_PC4    = 3'd4
    } rfwd_sel_e;

    typedef enum logic [2:0] {
        ST_FETCH,
        ST_DECODE,
        ST_EXECUTE,
        ST_MEM,
        ST_WB,
        ST_COMMIT,
        ST_TRAP
    } state_e;

    function automatic logic [3:0] alu_op(input logic funct7_5, input logic [2:0] funct3);
        return {funct7_5, funct3};
    endfunction

endpackage

// File: rtl/rv32i_mc_control_unit_ctrl_decoder.sv
// Combinational opcode/funct decode into the EXECUTE-step selects and strobes,
// plus the memory-access class and an illegal-opcode flag.
module ctrl_decoder
    import rv32i_mc_control_unit_pkg::*;
(
    input  logic [31:0] instr,
    output logic        illegal,
    output logic        is_load,
    output logic        is_store,
    output logic [3:0]  alu_control,
    output logic        alu_src,
    output logic        reg_we,
    output logic [2:0]  rfwd_sel,
    output logic        branch,
    output logic        jal,
    output logic        jalr
);

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic       funct7_5;
    logic       unused_bits;

    assign opcode      = instr[6:0];
    assign funct3      = instr[14:12];
    assign funct7_5    = instr[30];
    assign unused_bits = ^{instr[31], instr[29:15], instr[11:7]};

    // Only shifts carry funct7[5] on I-type; elsewhere bit 30 is immediate data.
    always_comb begin
        illegal     = 1'b0;
        is_load     = 1'b0;
        is_store    = 1'b0;
        alu_control = ALU_ADD;
        alu_src     = 1'b0;
        reg_we      = 1'b0;
        rfwd_sel    = RFWD_ALU;
        branch      = 1'b0;
        jal         = 1'b0;
        jalr        = 1'b0;
        case (opcode)
            OP_TYPE_R: begin
                alu_control = alu_op(funct7_5, funct3);
                reg_we      = 1'b1;
            end
            OP_TYPE_I: begin
                alu_control = (funct3 == FUNCT3_SLL || funct3 == FUNCT3_SR)
                              ? alu_op(funct7_5, funct3) : alu_op(1'b0, funct3);
                alu_src     = 1'b1;
                reg_we      = 1'b1;
            end
            OP_TYPE_L: begin
                is_load = 1'b1;
                alu_src = 1'b1;
            end
            OP_TYPE_S: begin
                is_store = 1'b1;
                alu_src  = 1'b1;
            end
            OP_TYPE_B: begin
                alu_control = alu_op(1'b0, funct3);
                branch      = 1'b1;
            end
            OP_TYPE_LUI: begin
                reg_we   = 1'b1;
                rfwd_sel = RFWD_IMM;
            end
            OP_TYPE_AUIPC: begin
                reg_we   = 1'b1;
                rfwd_sel = RFWD_PC_IMM;
            end
            OP_TYPE_JAL: begin
                reg_we   = 1'b1;
                rfwd_sel = RFWD_PC4;
                jal      = 1'b1;
            end
            OP_TYPE_JALR: begin
                reg_we   = 1'b1;
                rfwd_sel = RFWD_PC4;
                jal      = 1'b1;
                jalr     = 1'b1;
            end
            default: illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/rv32i_mc_control_unit.sv
// Multicycle RV32I sequencer: steps each instruction through FETCH..COMMIT,
// runs the data-bus handshake with an optional timeout, and counts retirements.
module rv32i_mc_control_unit
    import rv32i_mc_control_unit_pkg::*;
#(
    parameter int unsigned BUS_TIMEOUT = 16,
    parameter int unsigned CNT_W       = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [31:0]      instrCode,
    input  logic             busReady,
    output logic             PCEn,
    output logic             regFileWe,
    output logic [3:0]       aluControl,
    output logic             aluSrcMuxSel,
    output logic [2:0]       RFWDSrcMuxSel,
    output logic             branch,
    output logic             jal,
    output logic             jalr,
    output logic             busReq,
    output logic             busWe,
    output logic             halted,
    output logic [CNT_W-1:0] instret
);

    localparam bit          TIMEOUT_EN = (BUS_TIMEOUT != 0);
    localparam logic [31:0] WAIT_LAST  = 32'(BUS_TIMEOUT) - 32'd1;

    logic dec_illegal, dec_is_load, dec_is_store, dec_alu_src, dec_reg_we;
    logic dec_branch, dec_jal, dec_jalr;
    logic [3:0] dec_alu_control;
    logic [2:0] dec_rfwd_sel;

    ctrl_decoder u_decoder (
        .instr       (instrCode),
        .illegal     (dec_illegal),
        .is_load     (dec_is_load),
        .is_store    (dec_is_store),
        .alu_control (dec_alu_control),
        .alu_src     (dec_alu_src),
        .reg_we      (dec_reg_we),
        .rfwd_sel    (dec_rfwd_sel),
        .branch      (dec_branch),
        .jal         (dec_jal),
        .jalr        (dec_jalr)
    );

    state_e           state_q, state_d;
    logic [31:0]      wait_cnt_q, wait_cnt_d;
    logic [CNT_W-1:0] instret_q, instret_d;
    logic             halted_q, halted_d;
    logic             pc_en_q, pc_en_d, reg_file_we_q, reg_file_we_d;
    logic [3:0]       alu_control_q, alu_control_d;
    logic             alu_src_q, alu_src_d;
    logic [2:0]       rfwd_sel_q, rfwd_sel_d;
    logic             branch_q, branch_d, jal_q, jal_d, jalr_q, jalr_d;
    logic             bus_req_q, bus_req_d, bus_we_q, bus_we_d;

    // Outputs are computed for the state being entered, so every output is a flop.
    // branch/jal/jalr default to holding so they stay stable until the PC loads.
    always_comb begin
        state_d       = state_q;
        wait_cnt_d    = wait_cnt_q;
        instret_d     = instret_q;
        halted_d      = halted_q;
        pc_en_d       = 1'b0;
        reg_file_we_d = 1'b0;
        alu_control_d = ALU_ADD;
        alu_src_d     = 1'b0;
        rfwd_sel_d    = RFWD_ALU;
        branch_d      = branch_q;
        jal_d         = jal_q;
        jalr_d        = jalr_q;
        bus_req_d     = 1'b0;
        bus_we_d      = 1'b0;
        case (state_q)
            ST_FETCH: state_d = ST_DECODE;
            ST_DECODE: begin
                if (dec_illegal) begin
                    state_d  = ST_TRAP;
                    halted_d = 1'b1;
                end else begin
                    state_d       = ST_EXECUTE;
                    alu_control_d = dec_alu_control;
                    alu_src_d     = dec_alu_src;
                    reg_file_we_d = dec_reg_we;
                    rfwd_sel_d    = dec_rfwd_sel;
                    branch_d      = dec_branch;
                    jal_d         = dec_jal;
                    jalr_d        = dec_jalr;
                end
            end
            ST_EXECUTE: begin
                if (dec_is_load || dec_is_store) begin
                    state_d    = ST_MEM;
                    wait_cnt_d = '0;
                    bus_req_d  = 1'b1;
                    bus_we_d   = dec_is_store;
                end else begin
                    state_d = ST_COMMIT;
                    pc_en_d = 1'b1;
                end
            end
            ST_MEM: begin
                if (busReady) begin
                    wait_cnt_d = '0;
                    if (dec_is_load) begin
                        state_d       = ST_WB;
                        reg_file_we_d = 1'b1;
                        rfwd_sel_d    = RFWD_MEM;
                    end else begin
                        state_d = ST_COMMIT;
                        pc_en_d = 1'b1;
                    end
                end else if (TIMEOUT_EN && wait_cnt_q == WAIT_LAST) begin
                    state_d    = ST_TRAP;
                    halted_d   = 1'b1;
                    wait_cnt_d = '0;
                    branch_d   = 1'b0;
                    jal_d      = 1'b0;
                    jalr_d     = 1'b0;
                end else begin
                    wait_cnt_d = wait_cnt_q + 32'd1;
                    bus_req_d  = 1'b1;
                    bus_we_d   = dec_is_store;
                end
            end
            ST_WB: begin
                state_d = ST_COMMIT;
                pc_en_d = 1'b1;
            end
            ST_COMMIT: begin
                state_d   = ST_FETCH;
                instret_d = instret_q + CNT_W'(1);
                branch_d  = 1'b0;
                jal_d     = 1'b0;
                jalr_d    = 1'b0;
            end
            default: begin
                state_d  = ST_TRAP;
                halted_d = 1'b1;
                branch_d = 1'b0;
                jal_d    = 1'b0;
                jalr_d   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= ST_FETCH;
            wait_cnt_q    <= '0;
            instret_q     <= '0;
            halted_q      <= 1'b0;
            pc_en_q       <= 1'b0;
            reg_file_we_q <= 1'b0;
            alu_control_q <= '0;
            alu_src_q     <= 1'b0;
            rfwd_sel_q    <= '0;
            branch_q      <= 1'b0;
            jal_q         <= 1'b0;
            jalr_q        <= 1'b0;
            bus_req_q     <= 1'b0;
            bus_we_q      <= 1'b0;
        end else begin
            state_q       <= state_d;
            wait_cnt_q    <= wait_cnt_d;
            instret_q     <= instret_d;
            halted_q      <= halted_d;
            pc_en_q       <= pc_en_d;
            reg_file_we_q <= reg_file_we_d;
            alu_control_q <= alu_control_d;
            alu_src_q     <= alu_src_d;
            rfwd_sel_q    <= rfwd_sel_d;
            branch_q      <= branch_d;
            jal_q         <= jal_d;
            jalr_q        <= jalr_d;
            bus_req_q     <= bus_req_d;
            bus_we_q      <= bus_we_d;
        end
    end

    assign PCEn          = pc_en_q;
    assign regFileWe     = reg_file_we_q;
    assign aluControl    = alu_control_q;
    assign aluSrcMuxSel  = alu_src_q;
    assign RFWDSrcMuxSel = rfwd_sel_q;
    assign branch        = branch_q;
    assign jal           = jal_q;
    assign jalr          = jalr_q;
    assign busReq        = bus_req_q;
    assign busWe         = bus_we_q;
    assign halted        = halted_q;
    assign instret       = instret_q;

endmodule

// File: tb/tb_rv32i_mc_control_unit.sv
// Self-checking bench: a per-instruction cycle plan built from the sequencing
// rules is compared against the DUT outputs on every falling edge.
module tb_rv32i_mc_control_unit;

    localparam int unsigned BUS_TIMEOUT = 4;
    localparam int unsigned CNT_W       = 4;
    localparam int          OW          = 16 + CNT_W;

    logic             clk = 1'b0;
    logic             reset;
    logic [31:0]      instrCode;
    logic             busReady;
    logic             PCEn, regFileWe, aluSrcMuxSel, branch, jal, jalr;
    logic             busReq, busWe, halted;
    logic [3:0]       aluControl;
    logic [2:0]       RFWDSrcMuxSel;
    logic [CNT_W-1:0] instret;

    rv32i_mc_control_unit #(.BUS_TIMEOUT(BUS_TIMEOUT), .CNT_W(CNT_W)) dut (
        .clk           (clk),
        .reset         (reset),
        .instrCode     (instrCode),
        .busReady      (busReady),
        .PCEn          (PCEn),
        .regFileWe     (regFileWe),
        .aluControl    (aluControl),
        .aluSrcMuxSel  (aluSrcMuxSel),
        .RFWDSrcMuxSel (RFWDSrcMuxSel),
        .branch        (branch),
        .jal           (jal),
        .jalr          (jalr),
        .busReq        (busReq),
        .busWe         (busWe),
        .halted        (halted),
        .instret       (instret)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic             ready;
        logic             pcEn;
        logic             regWe;
        logic [3:0]       alu;
        logic             src;
        logic [2:0]       rfwd;
        logic             br;
        logic             jal;
        logic             jalr;
        logic             req;
        logic             we;
        logic             halted;
        logic [CNT_W-1:0] instret;
    } cycle_t;

    cycle_t           plan[$];
    cycle_t           expCur;
    bit               expValid = 1'b0;
    string            expTag = "";
    int               expIdx = 0;
    int               nChecks = 0;
    int               nFails = 0;
    int               pcEnIdx = -1;
    int               reqCount = 0;
    logic [CNT_W-1:0] retired = '0;

    function automatic logic [OW-1:0] packExp(input cycle_t c);
        return {c.pcEn, c.regWe, c.alu, c.src, c.rfwd, c.br, c.jal, c.jalr,
                c.req, c.we, c.halted, c.instret};
    endfunction

    function automatic logic [OW-1:0] actualVec();
        return {PCEn, regFileWe, aluControl, aluSrcMuxSel, RFWDSrcMuxSel, branch,
                jal, jalr, busReq, busWe, halted, instret};
    endfunction

    task automatic checkOutput(input string tag, input logic [OW-1:0] req);
        logic [OW-1:0] act;
        act = actualVec();
        nChecks++;
        if (act !== req) begin
            nFails++;
            $display("[TB] FAIL %s: outputs got %b required %b", tag, act, req);
        end
    endtask

    task automatic checkValue(input string tag, input logic [31:0] act, input logic [31:0] req);
        nChecks++;
        if (act !== req) begin
            nFails++;
            $display("[TB] FAIL %s: got %0d required %0d", tag, act, req);
        end
    endtask

    // Builds the cycle-by-cycle expectation of one instruction from the
    // sequencing rules; waits = number of busReady-low cycles in MEM.
    task automatic buildPlan(input logic [31:0] instr, input int waits);
        logic [6:0] op;
        logic [2:0] f3;
        bit isR, isI, isL, isS, isB, isLui, isAuipc, isJal, isJalr, timedOut;
        int nMem;
        cycle_t base, ex, held, c;
        op = instr[6:0];
        f3 = instr[14:12];
        isR = (op == 7'h33); isI = (op == 7'h13); isL = (op == 7'h03);
        isS = (op == 7'h23); isB = (op == 7'h63); isLui = (op == 7'h37);
        isAuipc = (op == 7'h17); isJal = (op == 7'h6F); isJalr = (op == 7'h67);
        plan.delete();
        base = '0;
        base.ready = 1'b1;
        base.instret = retired;
        plan.push_back(base);
        plan.push_back(base);
        if (!(isR || isI || isL || isS || isB || isLui || isAuipc || isJal || isJalr)) begin
            c = base;
            c.halted = 1'b1;
            repeat (6) plan.push_back(c);
            return;
        end
        ex = base;
        if (isR || (isI && (f3 == 3'd1 || f3 == 3'd5))) ex.alu = {instr[30], f3};
        else if (isI || isB) ex.alu = {1'b0, f3};
        ex.src  = isI || isL || isS;
        ex.br   = isB;
        ex.jal  = isJal || isJalr;
        ex.jalr = isJalr;
        ex.regWe = isR || isI || isLui || isAuipc || isJal || isJalr;
        ex.rfwd = isLui ? 3'd2 : isAuipc ? 3'd3 : (isJal || isJalr) ? 3'd4 : 3'd0;
        plan.push_back(ex);
        held = base;
        held.br = ex.br;
        held.jal = ex.jal;
        held.jalr = ex.jalr;
        if (isL || isS) begin
            timedOut = (BUS_TIMEOUT != 0) && (waits >= int'(BUS_TIMEOUT));
            nMem = timedOut ? int'(BUS_TIMEOUT) : waits + 1;
            for (int i = 0; i < nMem; i++) begin
                c = held;
                c.req = 1'b1;
                c.we = isS;
                c.ready = !timedOut && (i == waits);
                plan.push_back(c);
            end
            if (timedOut) begin
                c = base;
                c.halted = 1'b1;
                repeat (6) plan.push_back(c);
                return;
            end
            if (isL) begin
                c = held;
                c.regWe = 1'b1;
                c.rfwd = 3'd1;
                plan.push_back(c);
            end
        end
        c = held;
        c.pcEn = 1'b1;
        plan.push_back(c);
        retired = retired + CNT_W'(1);
    endtask

    // Called at 1 time unit after a rising edge; plays limit cycles of the plan
    // (all of it when limit < 0) and returns 1 unit after the following edge.
    task automatic applyStimulus(input logic [31:0] instr, input string tag, input int limit);
        int n;
        n = (limit < 0 || limit > plan.size()) ? plan.size() : limit;
        pcEnIdx  = -1;
        reqCount = 0;
        for (int i = 0; i < n; i++) begin
            instrCode = instr;
            busReady  = plan[i].ready;
            expCur    = plan[i];
            expTag    = tag;
            expIdx    = i;
            expValid  = 1'b1;
            @(posedge clk);
            #1;
        end
        expValid = 1'b0;
    endtask

    always @(negedge clk) begin
        if (expValid) begin
            checkOutput($sformatf("%s[%0d]", expTag, expIdx), packExp(expCur));
            if (PCEn === 1'b1) pcEnIdx = expIdx;
            if (busReq === 1'b1) reqCount++;
        end
    end

    logic [31:0] progInstr[16] = '{
        32'h002081B3, 32'h402081B3, 32'h4030D293, 32'h40000093,
        32'h123450B7, 32'h00001117, 32'h008000EF, 32'h000100E7,
        32'h00208463, 32'h0020C463, 32'h4020D063, 32'h0080A283,
        32'h0020A223, 32'h0080A283, 32'h0020A223, 32'h00208033
    };
    int progWaits[16] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2, 0, 3, 3, 0};

    initial begin
        reset = 1'b0;
        instrCode = 32'h00000013;
        busReady = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset", '0);
        reset = 1'b1;
        retired = '0;

        for (int i = 0; i < 16; i++) begin
            buildPlan(progInstr[i], progWaits[i]);
            applyStimulus(progInstr[i], $sformatf("prog%0d", i), -1);
            if (i == 0) begin
                checkValue("add_instret", 32'(instret), 32'd1);
                checkValue("add_pcen_cycle", pcEnIdx, 32'd3);
            end
            if (i == 11) begin
                checkValue("lw_pcen_cycle", pcEnIdx, 32'd7);
                checkValue("lw_busreq_cycles", reqCount, 32'd3);
            end
            if (i == 12) begin
                checkValue("sw_pcen_cycle", pcEnIdx, 32'd4);
                checkValue("sw_busreq_cycles", reqCount, 32'd1);
            end
            if (i == 15) checkValue("instret_wrap", 32'(instret), 32'd0);
        end

        buildPlan(32'h0000007F, 0);
        applyStimulus(32'h0000007F, "illegal", -1);
        checkValue("illegal_halted", 32'(halted), 32'd1);
        checkValue("illegal_pcen", 32'(PCEn), 32'd0);

        reset = 1'b0;
        #1;
        checkOutput("trap_reset", '0);
        @(posedge clk);
        #1;
        reset = 1'b1;
        retired = '0;

        buildPlan(32'h0080A283, 10);
        applyStimulus(32'h0080A283, "lw_timeout", -1);
        checkValue("timeout_busreq_cycles", reqCount, 32'd4);
        checkValue("timeout_halted", 32'(halted), 32'd1);
        checkValue("timeout_pcen_seen", pcEnIdx, 32'hFFFFFFFF);

        reset = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b1;
        retired = '0;

        buildPlan(32'h002081B3, 0);
        applyStimulus(32'h002081B3, "pre_abort_add", -1);
        buildPlan(32'h0080A283, 3);
        applyStimulus(32'h0080A283, "lw_abort", 5);
        checkValue("midmem_busreq", 32'(busReq), 32'd1);
        checkValue("midmem_instret", 32'(instret), 32'd1);
        reset = 1'b0;
        #1;
        checkOutput("midmem_reset", '0);
        @(posedge clk);
        #1;
        reset = 1'b1;
        retired = '0;

        buildPlan(32'h002081B3, 0);
        applyStimulus(32'h002081B3, "post_abort_add", -1);
        checkValue("post_abort_instret", 32'(instret), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
